multi_button_debounce: RTL and testbench
========================================

// Module: multi_button_debounce
// PURPOSE
//   Debounces CHANNELS push-buttons, all sampled on one shared slow tick (i_ena, 1-clk strobe).
//   Per channel it outputs a clean level, press/release one-clk pulses and an optional
//   long-press auto-repeat pulse.
//   Sits between the board buttons and the clock set/adjust control logic.
//   Replaces single-channel, press-only debouncing.
// PARAMETERS
//   CHANNELS       4   number of independent buttons
//   SAMPLES        3   consecutive agreeing ticks needed to accept a new level (>=2)
//   HOLD_TICKS     60  ticks held before first repeat pulse (~500 ms at 8.333 ms tick) (>=1)
//   REPEAT_TICKS   24  ticks between subsequent repeat pulses (~200 ms) (>=1)
//   BTN_ACTIVE_LOW 0   1: pin low = pressed (inverted after synchroniser)
// PORTS
//   i_clk         in   1         system clock
//   i_rst_n       in   1         reset, asynchronous, active-low
//   i_ena         in   1         sample tick, one i_clk wide; may be held high (every clk = tick)
//   i_btn         in   CHANNELS  raw asynchronous button pins
//   i_repeat_en   in   CHANNELS  per-channel auto-repeat enable
//   o_level       out  CHANNELS  debounced pressed level
//   o_press       out  CHANNELS  1-clk pulse on accepted press
//   o_release     out  CHANNELS  1-clk pulse on accepted release
//   o_repeat      out  CHANNELS  1-clk auto-repeat pulse while held
//   o_any_press   out  1         OR of o_press, same cycle
// BEHAVIOUR
//   Reset (async assert, sync release): all outputs 0, synchronisers/history 0, FSM IDLE, counters 0.
//   Per channel:
//   - 2-FF synchroniser on i_clk, then optional inversion.
//   - On each i_ena, shift the synced bit into a SAMPLES-bit history.
//   - All-ones with level=0 -> level 1; all-zeros with level=1 -> level 0. Otherwise hold.
//   - o_level, o_press, o_release and o_repeat are registered and update in the clk after
//     the accepting tick.
//   - Press latency: 2 clk sync + SAMPLES ticks.
//   - Pulses are exactly one i_clk wide, including when i_ena is held high.
//   FSM states (per channel), with hold counter cnt counting i_ena ticks:
//     IDLE   --accept press-->  HOLD (cnt=0, o_press)
//     HOLD   --tick, cnt+1==HOLD_TICKS & i_repeat_en-->  RPT (cnt=0, o_repeat)
//     RPT    --tick, cnt+1==REPEAT_TICKS & i_repeat_en-->  RPT (cnt=0, o_repeat)
//     HOLD/RPT --accept release-->  IDLE (cnt=0, o_release)
//   - i_repeat_en=0 in HOLD/RPT: cnt saturates at its limit and no o_repeat is produced.
//     Re-enabling fires a pulse on the next tick.
//   - cnt width = $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1); it never wraps.
//   - Release acceptance and repeat expiry on the same tick: release wins, no o_repeat.
//   - Button held through reset release: level starts 0, press is reported SAMPLES ticks later.
//   - Bounce shorter than SAMPLES ticks causes no level change and no pulses.
//   - Channels are fully independent; simultaneous events on several channels pulse in the same clk.
// STRUCTURE
//   - Shared include debounce_defs.vh: FSM state encodings
//     (IDLE=2'd0, HOLD=2'd1, RPT=2'd2) and default tick constants.
//   - Sub-module debounce_channel: one channel (sync, history, FSM, counter).
//   - Top level: generate loop of CHANNELS instances plus the o_any_press OR.
// TESTING
//   Bench settings: i_ena every 4 clk, SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2, CHANNELS=4.
//   1. i_btn[0] 0->1 clean
//      -> o_level[0]=1 and a single o_press[0] 1 clk after the 3rd tick.
//      -> on release, o_release[0] 3 ticks later.
//   2. i_btn[2] toggles every tick for 10 ticks -> no o_press/o_release, o_level[2] stays 0.
//   3. i_btn[1] held 15 ticks after acceptance, i_repeat_en[1]=1
//      -> o_repeat[1] at ticks 5,7,9,11,13,15 (6 pulses).
//   4. Same as 3 with i_repeat_en[1]=0 for 20 ticks -> zero o_repeat[1].
//      Enable at tick 20 -> pulse at tick 21.
//   5. i_btn[1] and i_btn[3] rise together
//      -> o_press[1] and o_press[3] in the same clk, o_any_press high exactly 1 clk.
//   6. i_rst_n low while channel 0 is in RPT
//      -> all outputs 0 immediately.
//      -> button still held after reset: o_press[0] after 3 ticks, no spurious o_release.

Source files
------------

// File: rtl/multi_button_debounce_pkg.sv
// Shared types and default timing for the multi-channel button debouncer.
package multi_button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } state_e;

  // Defaults assume an ~8.333 ms sample tick.
  localparam int DEF_SAMPLES      = 3;
  localparam int DEF_HOLD_TICKS   = 60;
  localparam int DEF_REPEAT_TICKS = 24;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_button_debounce_channel.sv
// One button: 2-FF synchroniser, tick-sampled history, press/hold/repeat FSM.
module multi_button_debounce_channel
  import multi_button_debounce_pkg::*;
#(
  parameter int SAMPLES        = DEF_SAMPLES,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ena,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CW = $clog2(max2(HOLD_TICKS, REPEAT_TICKS) + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] RPT_LIM  = CW'(REPEAT_TICKS);

  logic [1:0]         sync_q;
  logic [SAMPLES-1:0] hist_q, hist_d;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, lim;
  logic [CW:0]        cnt_inc;
  logic               level_q, level_d, press_q, press_d;
  logic               release_q, release_d, repeat_q, repeat_d;
  logic               btn_s;

  assign btn_s   = sync_q[1] ^ BTN_ACTIVE_LOW;
  assign hist_d  = i_ena ? {hist_q[SAMPLES-2:0], btn_s} : hist_q;
  assign lim     = (state_q == ST_HOLD) ? HOLD_LIM : RPT_LIM;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (i_ena) begin
      unique case (state_q)
        ST_IDLE: if (&hist_d) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end
        ST_HOLD, ST_RPT: begin
          // Release is checked first so it beats a coincident repeat expiry.
          if (~|hist_d) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else if (cnt_inc >= {1'b0, lim}) begin
            if (i_repeat_en) begin
              state_d  = ST_RPT;
              cnt_d    = '0;
              repeat_d = 1'b1;
            end else begin
              cnt_d = lim;
            end
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q    <= '0;
      hist_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_btn};
      hist_q    <= hist_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/multi_button_debounce.sv
// CHANNELS independent debounced buttons sharing one sample tick.
module multi_button_debounce
  import multi_button_debounce_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int SAMPLES        = DEF_SAMPLES,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ena,
  input  logic [CHANNELS-1:0] i_btn,
  input  logic [CHANNELS-1:0] i_repeat_en,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_repeat,
  output logic                o_any_press
);

  // Reset asserts asynchronously but leaves reset two clocks after the pin rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_button_debounce_channel #(
      .SAMPLES        (SAMPLES),
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (rst_n_s),
      .i_ena       (i_ena),
      .i_btn       (i_btn[g]),
      .i_repeat_en (i_repeat_en[g]),
      .o_level     (o_level[g]),
      .o_press     (o_press[g]),
      .o_release   (o_release[g]),
      .o_repeat    (o_repeat[g])
    );
  end

  assign o_any_press = |o_press;

endmodule

// File: tb/tb_multi_button_debounce.sv
// Random and directed button stimulus checked every clock against a run-length reference model.
module tb_multi_button_debounce;

  localparam int CH = 4, S = 3, HT = 5, RT = 2;

  logic          i_clk, i_rst_n, i_ena, o_any_press;
  logic [CH-1:0] i_btn, i_repeat_en, o_level, o_press, o_release, o_repeat;

  multi_button_debounce #(
    .CHANNELS(CH), .SAMPLES(S), .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ena(i_ena), .i_btn(i_btn),
    .i_repeat_en(i_repeat_en), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_repeat(o_repeat), .o_any_press(o_any_press)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;
  int ph;
  logic [CH-1:0] btn_nxt, ren_nxt;

  // Reference model: run length of identical samples plus ticks elapsed since press/repeat.
  int run_val[CH], run_len[CH], elapsed[CH], first[CH];
  logic [CH-1:0] exp_level, exp_press, exp_rel, exp_rpt;
  int cnt_press[CH], cnt_rel[CH], cnt_rpt[CH], cnt_any, cnt_both;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      run_val[c] = 0; run_len[c] = S; elapsed[c] = 0; first[c] = 1;
    end
    exp_level = '0; exp_press = '0; exp_rel = '0; exp_rpt = '0;
  endtask

  task automatic model_tick();
    exp_press = '0; exp_rel = '0; exp_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      int s;
      s = int'(i_btn[c]);
      if (s == run_val[c]) run_len[c]++;
      else begin run_val[c] = s; run_len[c] = 1; end
      if (!exp_level[c]) begin
        if (run_val[c] == 1 && run_len[c] >= S) begin
          exp_level[c] = 1'b1; exp_press[c] = 1'b1; elapsed[c] = 0; first[c] = 1;
        end
      end else if (run_val[c] == 0 && run_len[c] >= S) begin
        exp_level[c] = 1'b0; exp_rel[c] = 1'b1;
      end else begin
        elapsed[c]++;
        if (elapsed[c] >= (first[c] != 0 ? HT : RT) && i_repeat_en[c]) begin
          exp_rpt[c] = 1'b1; elapsed[c] = 0; first[c] = 0;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("level",     32'(o_level),     32'(exp_level));
    chk("press",     32'(o_press),     32'(exp_press));
    chk("release",   32'(o_release),   32'(exp_rel));
    chk("repeat",    32'(o_repeat),    32'(exp_rpt));
    chk("any_press", 32'(o_any_press), 32'(|exp_press));
  endtask

  task automatic step();
    @(negedge i_clk);
    ph = (ph + 1) % 4;
    if (ph == 1) begin i_btn = btn_nxt; i_repeat_en = ren_nxt; end
    i_ena = (ph == 0);
    if (ph == 0) model_tick();
    else begin exp_press = '0; exp_rel = '0; exp_rpt = '0; end
    @(posedge i_clk); #1;
    check_outs();
    for (int c = 0; c < CH; c++) begin
      if (o_press[c] === 1'b1)   cnt_press[c]++;
      if (o_release[c] === 1'b1) cnt_rel[c]++;
      if (o_repeat[c] === 1'b1)  cnt_rpt[c]++;
    end
    if (o_any_press === 1'b1) cnt_any++;
    if (o_press[1] === 1'b1 && o_press[3] === 1'b1) cnt_both++;
  endtask

  task automatic tick(input int n);
    repeat (4 * n) step();
  endtask

  task automatic do_reset();
    @(negedge i_clk); #2;
    i_rst_n = 1'b0; i_ena = 1'b0;
    #1;
    model_reset();
    check_outs();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (8) begin @(posedge i_clk); #1; check_outs(); end
    ph = 0;
  endtask

  int b0, b1, b2, b3;

  initial begin
    i_rst_n = 1'b0; i_ena = 1'b0; i_btn = '0; i_repeat_en = '0;
    btn_nxt = '0; ren_nxt = '0; ph = 0;
    cnt_any = 0; cnt_both = 0;
    for (int c = 0; c < CH; c++) begin cnt_press[c] = 0; cnt_rel[c] = 0; cnt_rpt[c] = 0; end
    model_reset();
    do_reset();

    // Clean press and release on channel 0.
    b0 = cnt_press[0]; b1 = cnt_rel[0];
    btn_nxt[0] = 1'b1; tick(2);
    chk("s1_no_early_level", 32'(o_level[0]), 32'd0);
    tick(1);
    chk("s1_level", 32'(o_level[0]), 32'd1);
    chk("s1_press_cnt", cnt_press[0] - b0, 1);
    tick(2);
    btn_nxt[0] = 1'b0; tick(2);
    chk("s1_no_early_rel", cnt_rel[0] - b1, 0);
    tick(1);
    chk("s1_rel_cnt", cnt_rel[0] - b1, 1);
    chk("s1_level_low", 32'(o_level[0]), 32'd0);
    tick(2);

    // Channel 2 bounces every tick.
    b0 = cnt_press[2]; b1 = cnt_rel[2];
    for (int i = 0; i < 10; i++) begin btn_nxt[2] = ~btn_nxt[2]; tick(1); end
    btn_nxt[2] = 1'b0; tick(3);
    chk("s2_press_cnt", cnt_press[2] - b0, 0);
    chk("s2_rel_cnt", cnt_rel[2] - b1, 0);
    chk("s2_level", 32'(o_level[2]), 32'd0);

    // Auto-repeat on channel 1.
    ren_nxt[1] = 1'b1; btn_nxt[1] = 1'b1; tick(3);
    b0 = cnt_rpt[1]; tick(15);
    chk("s3_rpt_cnt", cnt_rpt[1] - b0, 6);
    btn_nxt[1] = 1'b0; tick(3);
    chk("s3_level_low", 32'(o_level[1]), 32'd0);
    tick(2);

    // Repeat disabled for 20 ticks, then enabled.
    ren_nxt[1] = 1'b0; btn_nxt[1] = 1'b1; tick(3);
    b0 = cnt_rpt[1]; tick(20);
    chk("s4_rpt_off", cnt_rpt[1] - b0, 0);
    ren_nxt[1] = 1'b1; tick(1);
    chk("s4_rpt_on", cnt_rpt[1] - b0, 1);
    btn_nxt[1] = 1'b0; ren_nxt[1] = 1'b0; tick(4);

    // Simultaneous press on channels 1 and 3.
    b0 = cnt_any; b1 = cnt_both; b2 = cnt_press[1]; b3 = cnt_press[3];
    btn_nxt[1] = 1'b1; btn_nxt[3] = 1'b1; tick(3);
    chk("s5_any_cnt", cnt_any - b0, 1);
    chk("s5_both_cnt", cnt_both - b1, 1);
    chk("s5_p1", cnt_press[1] - b2, 1);
    chk("s5_p3", cnt_press[3] - b3, 1);
    btn_nxt[1] = 1'b0; btn_nxt[3] = 1'b0; tick(4);

    // Reset while channel 0 repeats, button held through it.
    ren_nxt[0] = 1'b1; btn_nxt[0] = 1'b1; tick(9);
    chk("s6_in_rpt", 32'(o_level[0]), 32'd1);
    do_reset();
    b0 = cnt_press[0]; b1 = cnt_rel[0];
    tick(3);
    chk("s6_press_cnt", cnt_press[0] - b0, 1);
    tick(3);
    chk("s6_no_rel", cnt_rel[0] - b1, 0);
    btn_nxt[0] = 1'b0; ren_nxt[0] = 1'b0; tick(4);

    // Random bouncing/holding on all channels.
    for (int k = 0; k < 150; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, (k < 75) ? 3 : 9) == 0) btn_nxt[c] = ~btn_nxt[c];
        if ($urandom_range(0, 15) == 0) ren_nxt[c] = ~ren_nxt[c];
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
